// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Brief    : Wait-stated data-memory controller with internal word RAM.
//            Feeds read data and a load strobe to the MDR.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
  parameter int DATA_W      = 24,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mdr_write,
  output logic              busy,
  output logic              done
);

  localparam int         c_depth    = 1 << ADDR_W;
  localparam logic [3:0] c_last_cnt = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS   = 2'd1,
    S_COMPLETE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_is_write;
  logic [DATA_W-1:0]   r_mem [c_depth];

  logic                w_accept;
  logic                w_commit;
  logic                w_op_write;
  logic [ADDR_W-1:0]   w_op_addr;
  logic [DATA_W-1:0]   w_op_wdata;

  assign w_accept = mem_write | mem_read;

  // With zero wait states the access commits straight from IDLE, before the
  // request fields have been latched, so the live inputs are used there.
  assign w_op_write = (r_state == S_IDLE) ? mem_write : r_is_write;
  assign w_op_addr  = (r_state == S_IDLE) ? addr      : r_addr;
  assign w_op_wdata = (r_state == S_IDLE) ? wdata     : r_wdata;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_commit   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_next = 4'd0;
          if (WAIT_CYCLES == 0) begin
            w_next   = S_COMPLETE;
            w_commit = 1'b1;
          end else begin
            w_next = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (r_cnt == c_last_cnt) begin
          w_next   = S_COMPLETE;
          w_commit = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      S_COMPLETE: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      rdata      <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_IDLE && w_accept) begin
        r_addr     <= addr;
        r_wdata    <= wdata;
        r_is_write <= mem_write;
      end
      if (w_commit && !w_op_write) begin
        rdata <= r_mem[w_op_addr];
      end
    end
  end

  // RAM is deliberately not cleared; reset only blocks a commit on its edge.
  always_ff @(posedge clk) begin
    if (!reset && w_commit && w_op_write) begin
      r_mem[w_op_addr] <= w_op_wdata;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_COMPLETE);
  assign mdr_write = (r_state == S_COMPLETE) && !r_is_write;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ctrl
// Brief    : Directed scoreboard bench for dmem_ctrl, 2 and 0 wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [7:0]  a_addr, b_addr;
  logic [23:0] a_wdata, b_wdata;
  logic [23:0] a_rdata, b_rdata;
  logic        a_mdr, a_busy, a_done, b_mdr, b_busy, b_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_read;
    logic [23:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] ref_mem [2][256];

  always #5 clk = ~clk;

  dmem_ctrl #(.DATA_W(24), .ADDR_W(8), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .reset(reset), .mem_read(a_rd), .mem_write(a_wr),
    .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata),
    .mdr_write(a_mdr), .busy(a_busy), .done(a_done)
  );

  dmem_ctrl #(.DATA_W(24), .ADDR_W(8), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(reset), .mem_read(b_rd), .mem_write(b_wr),
    .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata),
    .mdr_write(b_mdr), .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input bit b, input bit rd, input bit wr,
                       input logic [7:0] a, input logic [23:0] d);
    if (b) begin
      b_rd = rd; b_wr = wr; b_addr = a; b_wdata = d;
    end else begin
      a_rd = rd; a_wr = wr; a_addr = a; a_wdata = d;
    end
  endtask

  // One access: request held for a single edge, inputs scrambled afterwards
  // so the latched fields are what the access must use.
  task automatic access(input bit b, input bit rd, input bit wr,
                        input logic [7:0] a, input logic [23:0] d,
                        input bit inject, input string tag);
    exp_t e;
    int   n;
    bit   seen;
    int   lat;
    logic o_busy, o_done, o_mdr;
    logic [23:0] o_rdata;
    lat       = b ? 1 : 3;
    e.is_read = !wr && rd;
    e.data    = ref_mem[b][a];
    if (wr) ref_mem[b][a] = d;
    sb.push_back(e);
    drive(b, rd, wr, a, d);
    @(negedge clk);
    drive(b, 1'b0, 1'b0, a + 8'd1, ~d);
    n    = 1;
    seen = 0;
    while (!seen && n <= 8) begin
      if (inject && n == 1) drive(b, 1'b0, 1'b1, a, 24'h000001);
      if (inject && n == 2) drive(b, 1'b0, 1'b0, a + 8'd1, ~d);
      o_busy  = b ? b_busy  : a_busy;
      o_done  = b ? b_done  : a_done;
      o_mdr   = b ? b_mdr   : a_mdr;
      o_rdata = b ? b_rdata : a_rdata;
      chk({tag, "_busy"}, 32'(o_busy), 32'd1);
      if (o_done) begin
        seen = 1;
        e = sb.pop_front();
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_mdr_write"}, 32'(o_mdr), 32'(e.is_read));
        if (e.is_read) chk({tag, "_rdata"}, 32'(o_rdata), 32'(e.data));
      end else begin
        chk({tag, "_mdr_early"}, 32'(o_mdr), 32'd0);
      end
      @(negedge clk);
      n++;
    end
    if (!seen) begin
      errors++;
      checks++;
      $error("FAIL %s_timeout observed=no_done expected=done", tag);
      void'(sb.pop_front());
    end
    chk({tag, "_idle_busy"}, 32'(b ? b_busy : a_busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(b ? b_done : a_done), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 8'h00, 24'h0);
    drive(1, 0, 0, 8'h00, 24'h0);
    repeat (3) @(negedge clk);
    chk("rst_a_rdata", 32'(a_rdata), 32'd0);
    chk("rst_a_busy",  32'(a_busy),  32'd0);
    chk("rst_a_done",  32'(a_done),  32'd0);
    chk("rst_a_mdr",   32'(a_mdr),   32'd0);
    chk("rst_b_rdata", 32'(b_rdata), 32'd0);
    chk("rst_b_busy",  32'(b_busy),  32'd0);
    reset = 1'b0;
    @(negedge clk);

    access(0, 0, 1, 8'h10, 24'hABCDEF, 0, "wr_10");
    access(0, 1, 0, 8'h10, 24'h000000, 0, "rd_10");
    access(0, 1, 1, 8'h20, 24'h123456, 0, "both_20");
    access(0, 1, 0, 8'h20, 24'h000000, 0, "rd_20");
    access(0, 1, 0, 8'h10, 24'h000000, 1, "busy_rej");
    access(0, 1, 0, 8'h10, 24'h000000, 0, "rerd_10");

    // Write aborted by reset in its first ACCESS cycle.
    drive(0, 0, 1, 8'h10, 24'h555555);
    @(negedge clk);
    chk("abort_busy_before", 32'(a_busy), 32'd1);
    reset = 1'b1;
    drive(0, 0, 0, 8'h11, 24'h0);
    @(negedge clk);
    chk("abort_busy",  32'(a_busy),  32'd0);
    chk("abort_done",  32'(a_done),  32'd0);
    chk("abort_mdr",   32'(a_mdr),   32'd0);
    chk("abort_rdata", 32'(a_rdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    access(0, 1, 0, 8'h10, 24'h000000, 0, "rd_after_abort");

    // Zero wait states.
    access(1, 0, 1, 8'h10, 24'h0A0B0C, 0, "z_wr_10");
    access(1, 0, 1, 8'h11, 24'h111111, 0, "z_wr_11");
    access(1, 1, 0, 8'h10, 24'h000000, 0, "z_rd_10");

    drive(1, 1, 0, 8'h11, 24'h0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("z_b2b_done_%0d", i), 32'(b_done), 32'(i % 2));
      if (b_done) chk($sformatf("z_b2b_rdata_%0d", i), 32'(b_rdata), 32'(ref_mem[1][8'h11]));
    end
    drive(1, 0, 0, 8'h00, 24'h0);
    repeat (2) @(negedge clk);
    chk("z_b2b_idle", 32'(b_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
